// File: rtl/edge_sync_pkg.sv
// edge_sync_pkg: shared edge-mode encoding and synchroniser depth limits for edge_sync_bank
package edge_sync_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_RISE,
        EDGE_FALL,
        EDGE_BOTH
    } edge_sel_e;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/edge_sync_ch.sv
// edge_sync_ch: one channel (sync chain, optional EDGE_FILT_EN glitch filter, level, pulse, pend, ovf)
module edge_sync_ch
    import edge_sync_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYC    = 4,
    parameter logic RST_VAL     = 1'b0
)(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      data,
    input  edge_sel_e mode,
    input  logic      clr,
    output logic      level,
    output logic      pulse,
    output logic      pend,
    output logic      ovf
);

    if (FILT_CYC < 1 || FILT_CYC > 255) begin : g_bad_filt
        $error("edge_sync_ch: FILT_CYC out of range");
    end

    logic [SYNC_STAGES-1:0] chain;
    logic                   sync;
    logic                   acc;
    logic                   sel;

    assign sync = chain[SYNC_STAGES-1];

`ifdef EDGE_FILT_EN
    localparam int CW = $clog2(FILT_CYC + 1);
    logic [CW-1:0] cnt;

    assign acc = (sync != level) && (cnt == CW'(FILT_CYC - 1));

    // Count how long the synced value has disagreed with level; restart on agreement or acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= (sync == level || acc) ? '0 : cnt + 1'b1;
    end
`else
    assign acc = sync != level;
`endif

    assign sel = acc && (mode == EDGE_BOTH || mode == (sync ? EDGE_RISE : EDGE_FALL));

    // Synchroniser chain, accepted level and event flags; a new event beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            level <= RST_VAL;
            pulse <= 1'b0;
            pend  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], data};
            level <= acc ? sync : level;
            pulse <= sel;
            pend  <= sel | (pend & ~clr);
            ovf   <= clr ? 1'b0 : (ovf | (sel & pend));
        end
    end

endmodule

// File: rtl/edge_sync_bank.sv
// edge_sync_bank: CH-channel input synchroniser and edge-event detector; EDGE_FILT_EN adds a glitch filter
module edge_sync_bank
    import edge_sync_pkg::*;
#(
    parameter int          CH          = 4,
    parameter int          SYNC_STAGES = 2,
    parameter int          FILT_CYC    = 4,
    parameter logic [CH-1:0] RST_VAL   = '0
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   data_a,
    input  logic [2*CH-1:0] edge_sel,
    input  logic [CH-1:0]   clr,
    output logic [CH-1:0]   level_out,
    output logic [CH-1:0]   pulse_out,
    output logic [CH-1:0]   pend,
    output logic [CH-1:0]   ovf
);

    if (CH < 1 || CH > 32) begin : g_bad_ch
        $error("edge_sync_bank: CH out of range");
    end

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("edge_sync_bank: SYNC_STAGES out of range");
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        edge_sync_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_CYC   (FILT_CYC),
            .RST_VAL    (RST_VAL[i])
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .data (data_a[i]),
            .mode (edge_sel_e'(edge_sel[2*i +: 2])),
            .clr  (clr[i]),
            .level(level_out[i]),
            .pulse(pulse_out[i]),
            .pend (pend[i]),
            .ovf  (ovf[i])
        );
    end

endmodule

// File: tb/tb_edge_sync_bank.sv
// tb_edge_sync_bank: directed checks of edge_sync_bank with RST_VAL 0 and 1111 instances; honours EDGE_FILT_EN
module tb_edge_sync_bank;

`ifdef EDGE_FILT_EN
    localparam int S = 3;
    localparam int F = 4;
    localparam int D = S + F;
`else
    localparam int S = 2;
    localparam int F = 4;
    localparam int D = S + 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] data0, data1, clr0, clr1;
    logic [7:0] sel0, sel1;
    logic [3:0] lvl0, pul0, pend0, ovf0;
    logic [3:0] lvl1, pul1, pend1, ovf1;
    int         n_chk = 0;
    int         n_fail = 0;
    int         pc0[4];
    int         pc1[4];

    always #5 clk = ~clk;

    edge_sync_bank #(.CH(4), .SYNC_STAGES(S), .FILT_CYC(F), .RST_VAL(4'b0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_a(data0), .edge_sel(sel0), .clr(clr0),
        .level_out(lvl0), .pulse_out(pul0), .pend(pend0), .ovf(ovf0)
    );

    edge_sync_bank #(.CH(4), .SYNC_STAGES(S), .FILT_CYC(F), .RST_VAL(4'b1111)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_a(data1), .edge_sel(sel1), .clr(clr1),
        .level_out(lvl1), .pulse_out(pul1), .pend(pend1), .ovf(ovf1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            pc0[i] += int'(pul0[i]);
            pc1[i] += int'(pul1[i]);
        end
    endtask

    task automatic clear_pc0;
        for (int i = 0; i < 4; i++) pc0[i] = 0;
    endtask

    task automatic clear_pc1;
        for (int i = 0; i < 4; i++) pc1[i] = 0;
    endtask

    task automatic square;
        for (int p = 0; p < 2; p++) begin
            data0[3:1] = 3'b111;
            repeat (4) tick();
            data0[3:1] = 3'b000;
            repeat (4) tick();
        end
        repeat (12) tick();
    endtask

    initial begin
        clear_pc0();
        clear_pc1();
        data0 = 4'b0000;
        data1 = 4'b1111;
        clr0  = 4'b0000;
        clr1  = 4'b0000;
        sel0  = {2'b11, 2'b00, 2'b10, 2'b01};
        sel1  = {2'b11, 2'b11, 2'b10, 2'b01};
        #12;
        check("rst_lvl0", 32'(lvl0), 0);
        check("rst_lvl1", 32'(lvl1), 15);
        check("rst_pend0", 32'(pend0), 0);
        check("rst_pulse1", 32'(pul1), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) tick();
        check("rel_pend0", 32'(pend0), 0);
        check("rel_lvl1", 32'(lvl1), 15);

        data0[0] = 1'b1;
        repeat (D - 1) tick();
        check("rise_pre_lvl", 32'(lvl0[0]), 0);
        tick();
        check("rise_lvl", 32'(lvl0[0]), 1);
        check("rise_pulse", 32'(pul0[0]), 1);
        check("rise_pend", 32'(pend0[0]), 1);
        tick();
        check("rise_pulse_1cyc", 32'(pul0[0]), 0);
        check("rise_ovf", 32'(ovf0[0]), 0);

        clear_pc0();
        square();
        check("sq_fall_pulses", 32'(pc0[1]), 2);
        check("sq_none_pulses", 32'(pc0[2]), 0);
        check("sq_both_pulses", 32'(pc0[3]), 4);
        check("sq_pend", 32'(pend0), 32'hB);
        check("sq_ovf", 32'(ovf0), 32'hA);
        check("sq_lvl", 32'(lvl0), 1);

        clr0 = 4'b1010;
        tick();
        clr0 = 4'b0000;
        check("clr_pend", 32'(pend0), 1);
        check("clr_ovf", 32'(ovf0), 0);

        sel0[3:2] = 2'b11;
        clear_pc0();
        square();
        check("sq2_both_pulses", 32'(pc0[1]), 4);
        check("sq2_pend", 32'(pend0[1]), 1);
        check("sq2_ovf", 32'(ovf0[1]), 1);

        clr0[3] = 1'b1;
        tick();
        clr0[3] = 1'b0;
        check("ov_clr_pend", 32'(pend0[3]), 0);
        data0[3] = 1'b1;
        repeat (D) tick();
        check("ov_first_pend", 32'(pend0[3]), 1);
        check("ov_first_ovf", 32'(ovf0[3]), 0);
        data0[3] = 1'b0;
        repeat (D) tick();
        check("ov_second_ovf", 32'(ovf0[3]), 1);
        data0[3] = 1'b1;
        repeat (D - 1) tick();
        clr0[3] = 1'b1;
        tick();
        clr0[3] = 1'b0;
        check("ov_clr_edge_pulse", 32'(pul0[3]), 1);
        check("ov_clr_edge_pend", 32'(pend0[3]), 1);
        check("ov_clr_edge_ovf", 32'(ovf0[3]), 0);
        repeat (4) tick();

        clear_pc0();
`ifdef EDGE_FILT_EN
        data0[3] = 1'b0;
        repeat (3) tick();
        data0[3] = 1'b1;
        repeat (12) tick();
        check("glitch3_pulses", 32'(pc0[3]), 0);
        check("glitch3_lvl", 32'(lvl0[3]), 1);
        data0[3] = 1'b0;
        repeat (4) tick();
        data0[3] = 1'b1;
        repeat (D - 5) tick();
        check("hold4_pre_lvl", 32'(lvl0[3]), 1);
        tick();
        check("hold4_lvl", 32'(lvl0[3]), 0);
        repeat (12) tick();
        check("hold4_back_lvl", 32'(lvl0[3]), 1);
        check("hold4_pulses", 32'(pc0[3]), 2);
`else
        data0[3] = 1'b0;
        tick();
        data0[3] = 1'b1;
        repeat (8) tick();
        check("toggle_pulses", 32'(pc0[3]), 2);
        check("toggle_lvl", 32'(lvl0[3]), 1);
`endif

        check("dut1_quiet", 32'(pc1[0] + pc1[1] + pc1[2] + pc1[3]), 0);

        data0 = 4'b0000;
        repeat (2 * D + 4) tick();
        data0[0] = 1'b1;
        repeat (S + 2) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_lvl0", 32'(lvl0), 0);
        check("mid_rst_pend0", 32'(pend0), 0);
        check("mid_rst_ovf0", 32'(ovf0), 0);
        check("mid_rst_pulse0", 32'(pul0), 0);
        check("mid_rst_lvl1", 32'(lvl1), 15);
        data1 = 4'b1100;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_pc0();
        clear_pc1();
        repeat (D - 1) tick();
        check("restart_pre_lvl", 32'(lvl0[0]), 0);
        tick();
        check("restart_lvl", 32'(lvl0[0]), 1);
        check("restart_pulse", 32'(pul0[0]), 1);
        check("rv1_pulse", 32'(pul1), 2);
        check("rv1_lvl", 32'(lvl1), 12);
        repeat (8) tick();
        check("rv1_rise_none", 32'(pc1[0]), 0);
        check("rv1_fall_one", 32'(pc1[1]), 1);
        check("rv1_same_none", 32'(pc1[2] + pc1[3]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
